pd_math_gen: RTL and testbench

//  Parametrised PD(+I) error-term generator for the inertial balance loop.
//  - Takes desired/actual heading samples and produces saturated P, D and optional I terms.
//  - Feeds the motor-drive summation.
//  - Adds to the fixed PD generator: parametrised widths, gains and D-queue depth,
//    an output-valid strobe, D-queue priming, a synchronous clear, and an optional integrator.

---
 rtl/pd_math_pkg.sv | 37 +++
 rtl/pd_delay_queue.sv | 70 +++++++
 rtl/pd_math_gen.sv | 168 ++++++++++++++++
 tb/tb_pd_math_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_math_pkg.sv
// ---------------------------------------------------------------------------
// pd_math_pkg
//   Shared definitions for the PD(+I) error-term generator:
//     - default widths and gains (used as the top-level parameter defaults)
//     - err_t / dterm_t for the default configuration
//     - sat_signed(): width-generic signed saturation helper
//   Optional feature macro used elsewhere in this slice: PD_MATH_ITERM_EN
// ---------------------------------------------------------------------------
package pd_math_pkg;

   localparam int IN_W_DEF    = 16;
   localparam int ERR_W_DEF   = 10;
   localparam int DSAT_W_DEF  = 7;
   localparam int D_DEPTH_DEF = 12;
   localparam int P_NUM_DEF   = 5;
   localparam int P_SHIFT_DEF = 3;
   localparam int D_GAIN_DEF  = 7;
   localparam int INT_W_DEF   = 16;
   localparam int I_SHIFT_DEF = 6;

   typedef logic signed [ERR_W_DEF-1:0]  err_t;
   typedef logic signed [DSAT_W_DEF+4:0] dterm_t;

   // Clamp a sign-extended value into the range of a w-bit signed number.
   // Callers truncate the 64-bit result to w bits with a size cast.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/pd_delay_queue.sv
// ---------------------------------------------------------------------------
// pd_delay_queue
//   DEPTH x W shift register holding past error samples for the D term.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     push        shift in din (one accepted sample)
//     clr         synchronous clear of contents, fill count and primed;
//                 wins over push in the same cycle
//     din         newest sample
//     dout        oldest sample (DEPTH pushes ago)
//     primed      queue holds DEPTH samples since the last reset/clear
//     fill_cnt    debug view of the fill count
// ---------------------------------------------------------------------------
module pd_delay_queue
   import pd_math_pkg::*;
#(
   parameter int DEPTH = D_DEPTH_DEF,
   parameter int W     = ERR_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         clr,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         primed,
   output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     q_q [DEPTH];
   logic [W-1:0]     q_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             primed_q, primed_d;

   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
         cnt_d    = '0;
         primed_d = 1'b0;
      end else if (push) begin
         for (int i = DEPTH - 1; i > 0; i--) q_d[i] = q_q[i-1];
         q_d[0] = din;
         // Fill count saturates at DEPTH; primed follows the new count.
         if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
         primed_d = (cnt_d == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
         cnt_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
      end
   end

   assign dout     = q_q[DEPTH-1];
   assign primed   = primed_q;
   assign fill_cnt = cnt_q;

endmodule

// File: rtl/pd_math_gen.sv
// ---------------------------------------------------------------------------
// pd_math_gen
//   Parametrised PD(+I) error-term generator for the inertial balance loop.
//   err = actual - desired, saturated, then three pipeline stages produce
//   the P, D and (optional) I terms for the motor-drive summation.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     vld               new desired/actual sample (single-cycle strobe)
//     clr               synchronous clear of loop history (beats vld)
//     desired, actual   signed IN_W positions
//     pterm             signed ERR_W P term
//     dterm             signed DSAT_W+5 D term
//     iterm             signed ERR_W I term (0 unless PD_MATH_ITERM_EN)
//     out_vld           terms updated this cycle
//     primed            D queue holds D_DEPTH samples
//   Handshake: vld is a push-only strobe with no back-pressure; every vld
//   not coinciding with clr is accepted and yields exactly one out_vld pulse
//   three cycles later unless a clr or reset lands while it is in flight.
//   Optional feature macro: PD_MATH_ITERM_EN enables the saturating
//   integrator; without it iterm is tied to 0 and no integrator is built.
// ---------------------------------------------------------------------------
module pd_math_gen
   import pd_math_pkg::*;
#(
   parameter int IN_W    = IN_W_DEF,
   parameter int ERR_W   = ERR_W_DEF,
   parameter int DSAT_W  = DSAT_W_DEF,
   parameter int D_DEPTH = D_DEPTH_DEF,
   parameter int P_NUM   = P_NUM_DEF,
   parameter int P_SHIFT = P_SHIFT_DEF,
   parameter int D_GAIN  = D_GAIN_DEF
`ifdef PD_MATH_ITERM_EN
   ,
   parameter int INT_W   = INT_W_DEF,
   parameter int I_SHIFT = I_SHIFT_DEF
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       vld,
   input  logic                       clr,
   input  logic signed [IN_W-1:0]     desired,
   input  logic signed [IN_W-1:0]     actual,
   output logic signed [ERR_W-1:0]    pterm,
   output logic signed [DSAT_W+4:0]   dterm,
   output logic signed [ERR_W-1:0]    iterm,
   output logic                       out_vld,
   output logic                       primed
);

   localparam int DT_W = DSAT_W + 5;
   localparam int DD_W = ERR_W + 1;

   logic signed [IN_W:0]     err_raw;
   logic signed [DD_W-1:0]   dd;
   logic signed [DSAT_W-1:0] dd_sat;
   logic [ERR_W-1:0]         q_last;
   logic                     primed_w;
   logic [$clog2(D_DEPTH+1)-1:0] fill_cnt;

   logic signed [ERR_W-1:0]  err_s1_q, err_s1_d;
   logic                     v1_q, v1_d;
   logic signed [ERR_W-1:0]  p2_q, p2_d;
   logic signed [DT_W-1:0]   d2_q, d2_d;
   logic                     v2_q, v2_d;
   logic signed [ERR_W-1:0]  pterm_q, pterm_d;
   logic signed [DT_W-1:0]   dterm_q, dterm_d;
   logic                     out_vld_q, out_vld_d;

   // History of accepted S1 errors; compared sample sits at the far end.
   pd_delay_queue #(
      .DEPTH (D_DEPTH),
      .W     (ERR_W)
   ) u_dq (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (v1_q),
      .clr      (clr),
      .din      (err_s1_q),
      .dout     (q_last),
      .primed   (primed_w),
      .fill_cnt (fill_cnt)
   );

   always_comb begin
      // S0: one extra bit so the subtraction cannot wrap before saturation.
      err_raw  = $signed({actual[IN_W-1], actual}) - $signed({desired[IN_W-1], desired});
      err_s1_d = ERR_W'(sat_signed(err_raw, ERR_W));
      v1_d     = vld & ~clr;

      // S2: products formed at 64 bits, then narrowed; >>> floors toward -inf.
      p2_d   = ERR_W'((64'(err_s1_q) * 64'(P_NUM)) >>> P_SHIFT);
      dd     = DD_W'(err_s1_q) - DD_W'($signed(q_last));
      dd_sat = DSAT_W'(sat_signed(dd, DSAT_W));
      // primed is the pre-update value, so the priming sample itself gives 0.
      d2_d   = primed_w ? DT_W'(64'(dd_sat) * 64'(D_GAIN)) : '0;
      v2_d   = v1_q & ~clr;

      // S3: outputs only move on an accepted, un-cleared sample.
      out_vld_d = v2_q & ~clr;
      pterm_d   = pterm_q;
      dterm_d   = dterm_q;
      if (out_vld_d) begin
         pterm_d = p2_q;
         dterm_d = d2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_s1_q  <= '0;
         v1_q      <= 1'b0;
         p2_q      <= '0;
         d2_q      <= '0;
         v2_q      <= 1'b0;
         pterm_q   <= '0;
         dterm_q   <= '0;
         out_vld_q <= 1'b0;
      end else begin
         err_s1_q  <= err_s1_d;
         v1_q      <= v1_d;
         p2_q      <= p2_d;
         d2_q      <= d2_d;
         v2_q      <= v2_d;
         pterm_q   <= pterm_d;
         dterm_q   <= dterm_d;
         out_vld_q <= out_vld_d;
      end
   end

`ifdef PD_MATH_ITERM_EN
   logic signed [INT_W-1:0] integ_q, integ_d;
   logic signed [ERR_W-1:0] i2_q, i2_d;
   logic signed [ERR_W-1:0] iterm_q, iterm_d;

   always_comb begin
      integ_d = integ_q;
      if (clr)       integ_d = '0;
      else if (v1_q) integ_d = INT_W'(sat_signed(64'(integ_q) + 64'(err_s1_q), INT_W));
      // I term uses the integrator before this sample is added in.
      i2_d    = ERR_W'(sat_signed(integ_q >>> I_SHIFT, ERR_W));
      iterm_d = iterm_q;
      if (out_vld_d) iterm_d = i2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_q <= '0;
         i2_q    <= '0;
         iterm_q <= '0;
      end else begin
         integ_q <= integ_d;
         i2_q    <= i2_d;
         iterm_q <= iterm_d;
      end
   end

   assign iterm = iterm_q;
`else
   assign iterm = '0;
`endif

   assign pterm   = pterm_q;
   assign dterm   = dterm_q;
   assign out_vld = out_vld_q;
   assign primed  = primed_w;

endmodule

// File: tb/tb_pd_math_gen.sv
// ---------------------------------------------------------------------------
// tb_pd_math_gen
//   Directed + randomised bench for pd_math_gen (default parameters).
//   Reference model: history of accepted errors and an integer integrator,
//   computing each expected (pterm, dterm, iterm) from plain arithmetic.
//   Build with +define+PD_MATH_ITERM_EN to check the integrator variant.
// ---------------------------------------------------------------------------
module tb_pd_math_gen;
   import pd_math_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vld = 1'b0;
   logic clr = 1'b0;
   logic signed [15:0] desired = '0;
   logic signed [15:0] actual  = '0;
   err_t   pterm;
   dterm_t dterm;
   err_t   iterm;
   logic   out_vld;
   logic   primed;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pd_math_gen dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld     (vld),
      .clr     (clr),
      .desired (desired),
      .actual  (actual),
      .pterm   (pterm),
      .dterm   (dterm),
      .iterm   (iterm),
      .out_vld (out_vld),
      .primed  (primed)
   );

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   int          pulses   = 0;
   logic [31:0] exp_q[$];          // {p[9:0], d[11:0], i[9:0]}
   int          due_q[$];          // cycle at which each entry must appear
   int          hist[$];           // accepted saturated errors since clear
   int          integ = 0;
   logic [31:0] last_exp = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // ---------------- reference model ----------------
   task automatic model_accept(input int e, input int c);
      int es, p, d, i;
      es = clamp(e, -512, 511);
      p  = (es * 5) >>> 3;
      d  = (hist.size() >= 12) ? clamp(es - hist[0], -64, 63) * 7 : 0;
      hist.push_back(es);
      if (hist.size() > 12) void'(hist.pop_front());
`ifdef PD_MATH_ITERM_EN
      i     = clamp(integ >>> 6, -512, 511);
      integ = clamp(integ + es, -32768, 32767);
`else
      i = 0;
`endif
      last_exp = {p[9:0], d[11:0], i[9:0]};
      exp_q.push_back(last_exp);
      due_q.push_back(c + 3);
   endtask

   task automatic model_clear();
      hist.delete();
      integ = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int des, input int act);
      @(negedge clk);
      desired = des[15:0];
      actual  = act[15:0];
      vld     = 1'b1;
      clr     = 1'b0;
      model_accept(int'(actual) - int'(desired), cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld = 1'b0;
         clr = 1'b0;
      end
   endtask

   task automatic send(input int des, input int act);
      drive(des, act);
      idle(1);
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      vld = 1'b0;
      clr = 1'b1;
      model_clear();
      @(negedge clk);
      clr = 1'b0;
   endtask

   function automatic int rand_pos();
      return int'($urandom_range(0, 65535));
   endfunction

   // ---------------- output monitor ----------------
   logic [31:0] mon_e;
   int          mon_due;
   err_t        mon_p;
   dterm_t      mon_d;
   err_t        mon_i;

   always @(negedge clk) begin
      if (out_vld === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("spurious_out_vld", 32'd1, 32'd0);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_due = due_q.pop_front();
            mon_p   = mon_e[31:22];
            mon_d   = mon_e[21:10];
            mon_i   = mon_e[9:0];
            chk("latency", cyc, mon_due);
            chk("pterm", 32'(pterm), 32'(mon_p));
            chk("dterm", 32'(dterm), 32'(mon_d));
            chk("iterm", 32'(iterm), 32'(mon_i));
         end
      end
   end

   // ---------------- directed sequence ----------------
   int   p0;
   int   r;
   err_t hold_p;
   dterm_t hold_d;
   err_t hold_i;

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_pterm", 32'(pterm), 32'd0);
      chk("rst_dterm", 32'(dterm), 32'd0);
      chk("rst_iterm", 32'(iterm), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_primed", 32'(primed), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // P term and latency
      p0 = pulses;
      send(0, 100);
      idle(4);
      chk("p_pulse_count", pulses - p0, 1);
      chk("p_pterm_100", 32'(pterm), 32'(62));
      chk("p_dterm_unprimed", 32'(dterm), 32'd0);

      // Error saturation both ways
      send(-32768, 32767);
      idle(4);
      chk("sat_pos_pterm", 32'(pterm), 32'(319));
      send(32767, -32768);
      idle(4);
      chk("sat_neg_pterm", 32'(pterm), 32'(-320));

      // Priming of the D queue
      clear_pulse();
      idle(2);
      chk("prime_after_clr", 32'(primed), 32'd0);
      for (int k = 0; k < 11; k++) begin
         r = rand_pos();
         send(r, r);
      end
      idle(2);
      chk("prime_after_11", 32'(primed), 32'd0);
      r = rand_pos();
      send(r, r);
      idle(3);
      chk("prime_after_12", 32'(primed), 32'd1);
      chk("prime_12_dterm", 32'(dterm), 32'd0);
      send(0, 100);
      idle(4);
      chk("d_pos_sat", 32'(dterm), 32'(441));
      send(0, -100);
      idle(4);
      chk("d_neg_sat", 32'(dterm), 32'(-448));

      // clr together with vld: sample dropped, outputs hold
      hold_p = last_exp[31:22];
      hold_d = last_exp[21:10];
      hold_i = last_exp[9:0];
      p0 = pulses;
      @(negedge clk);
      desired = 16'sd0;
      actual  = 16'sd200;
      vld     = 1'b1;
      clr     = 1'b1;
      model_clear();
      idle(6);
      chk("clr_no_out_vld", pulses - p0, 0);
      chk("clr_primed", 32'(primed), 32'd0);
      chk("clr_hold_pterm", 32'(pterm), 32'(hold_p));
      chk("clr_hold_dterm", 32'(dterm), 32'(hold_d));
      chk("clr_hold_iterm", 32'(iterm), 32'(hold_i));
      for (int k = 0; k < 13; k++) begin
         r = rand_pos();
         send(r, r + int'($urandom_range(0, 400)) - 200);
      end
      idle(4);

      // Back-to-back samples
      p0 = pulses;
      for (int k = 0; k < 5; k++) drive(0, 40 * k - 90);
      idle(5);
      chk("b2b_pulse_count", pulses - p0, 5);

      // Randomised traffic with random gaps (0 = back-to-back)
      for (int k = 0; k < 40; k++) begin
         r = rand_pos();
         if ($urandom_range(0, 3) == 0) drive(r, rand_pos());
         else                           drive(r, r + int'($urandom_range(0, 1200)) - 600);
         idle(int'($urandom_range(0, 3)));
      end
      idle(5);

      // Integrator ramp
      clear_pulse();
      for (int k = 0; k < 64; k++) send(0, 64);
      idle(4);
`ifdef PD_MATH_ITERM_EN
      chk("iterm_64th", 32'(iterm), 32'(63));
`else
      chk("iterm_64th", 32'(iterm), 32'd0);
`endif
      send(0, 64);
      idle(4);
`ifdef PD_MATH_ITERM_EN
      chk("iterm_65th", 32'(iterm), 32'(64));
`else
      chk("iterm_65th", 32'(iterm), 32'd0);
`endif
      chk("ramp_pterm", 32'(pterm), 32'(40));

      // Reset while a sample sits in S2
      p0 = pulses;
      drive(0, 50);
      @(negedge clk);
      vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      due_q.delete();
      model_clear();
      idle(2);
      chk("midrst_pterm", 32'(pterm), 32'd0);
      chk("midrst_dterm", 32'(dterm), 32'd0);
      chk("midrst_iterm", 32'(iterm), 32'd0);
      chk("midrst_primed", 32'(primed), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);
      chk("midrst_no_out_vld", pulses - p0, 0);
      chk("midrst_pterm_after", 32'(pterm), 32'd0);

      chk("all_expected_seen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
